scs8hd_rr_arb_ctl: RTL and testbench
====================================

Name: scs8hd_rr_arb_ctl

Overview:
- Round-robin arbiter/controller that shares one scs8hd combinational datapath resource (e.g. an a21o-based select/merge stage) between N_REQ requesters.
- Issues a registered one-hot grant and holds it while the owner keeps its request asserted.
- Enforces an optional maximum hold time and a fixed one-cycle turnaround gap between owners.
- Sits between requester logic and the shared cell cluster; behavioural model for library-level simulation.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
- REQ  input  N_REQ  per-requester request level; held high while ownership is wanted.
- GNT  output  N_REQ  registered one-hot grant; all zero when no owner.
- GNT_ID  output  3  binary index of the owner; valid only while BUSY=1, otherwise 0.
- BUSY  output  1  high while any GNT bit is set.
- TIMEOUT  output  1  one-cycle pulse in the cycle GNT drops due to a MAX_HOLD revoke.
- vpwr, vgnd, vpb, vnb  input  1  present only under SC_USE_PG_PIN; tied supply1/supply0 otherwise; no functional effect.

Behaviour:
- Reset (RESET=1 at a CLK edge): GNT=0, GNT_ID=0, BUSY=0, TIMEOUT=0, state=IDLE, PTR=0, HCNT=0. RESET overrides everything, including mid-grant; the grant drops the next cycle with no TIMEOUT pulse.
- States: IDLE, OWN, TURN.
- Pick function: the first set REQ bit searching circularly from PTR upward (PTR, PTR+1, ..., wrapping mod N_REQ).
- IDLE:
  - If REQ!=0: go to OWN and register GNT=onehot(pick), GNT_ID=pick, BUSY=1, HCNT=1.
  - Grant latency is one cycle from the first sampled REQ.
- OWN, owner o:
  - If REQ[o]=0 is sampled: GNT cleared next cycle, go to TURN, PTR=(o+1) mod N_REQ.
  - Else if MAX_HOLD!=0 and HCNT==MAX_HOLD: same transition as a release, and TIMEOUT=1 for that cycle.
  - Else stay in OWN with HCNT+1; HCNT saturates and never wraps.
  - Grant length on timeout is exactly MAX_HOLD cycles.
  - REQ changes on non-owners are ignored while in OWN.
- TURN:
  - GNT=0 for exactly one cycle.
  - If REQ!=0: go directly to OWN using the updated PTR. Otherwise go to IDLE.
- A revoked requester that keeps REQ high competes normally at the lowest priority. If it is the only requester, it is regranted after the one-cycle gap.
- Invariants:
  - GNT is always zero or one-hot.
  - BUSY == |GNT.
  - GNT never changes owner without an intervening all-zero cycle.
- PTR wraps from N_REQ-1 to 0.
- Requesting bits at index >= N_REQ do not exist; GNT_ID upper bits are zero.

Decomposition:
- Package scs8hd_arb_pkg:
  - state encoding: IDLE=2'b00, OWN=2'b01, TURN=2'b10; 2'b11 is illegal and recovers to IDLE.
  - constant MAX_N_REQ=8.
  - a function for one-hot-to-index.
- One sub-module, scs8hd_rr_pick: purely combinational rotate-priority picker with inputs REQ and PTR, outputs one-hot PICK and VALID. It is reused by future multi-resource schedulers.

Test Plan:
- RESET=1 for 2 cycles with REQ=4'b1111 -> GNT=0, BUSY=0, TIMEOUT=0 throughout. On release, GNT=4'b0001 one cycle later.
- REQ=4'b0100 held 3 cycles then dropped, MAX_HOLD=16 -> GNT=4'b0100 for 3 cycles, GNT_ID=2, then GNT=0, PTR=3.
- REQ=4'b1111 held constantly -> grant order 0,1,2,3,0, each lasting 16 cycles with TIMEOUT pulses, separated by exactly one zero cycle.
- Only REQ[1] held high, MAX_HOLD=4 -> GNT=4'b0010 for 4 cycles, 1 gap cycle with TIMEOUT=1, then regranted; the pattern repeats.
- RESET asserted on the 2nd cycle of ownership by requester 3 -> next cycle GNT=0, TIMEOUT=0, PTR=0. After RESET is released with REQ=4'b1001, the grant goes to requester 0.
- MAX_HOLD=0 with REQ[2] held for 40 cycles -> GNT=4'b0100 for all 40 cycles, TIMEOUT never asserts, HCNT saturates without a grant drop.

Source files
------------

// File: rtl/scs8hd_arb_pkg.sv
// Shared types and helpers for the scs8hd round-robin arbitration blocks.
package scs8hd_arb_pkg;

  // Largest requester count any arbiter in this family supports.
  localparam int MAX_N_REQ = 8;

  // Width of a requester index / rotation pointer.
  localparam int PTR_W = 3;

  // Controller states; the unused 2'b11 encoding falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN  = 2'b01,
    TURN = 2'b10
  } arbState_t;

  // Converts a one-hot (or all-zero) vector into a binary index.
  function automatic logic [PTR_W-1:0] onehotToIndex(input logic [MAX_N_REQ-1:0] oneHot);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N_REQ; i++) begin
      if (oneHot[i]) begin
        idx = idx | PTR_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/scs8hd_rr_pick.sv
// Combinational rotate-priority picker: selects the first set request bit
// found by searching circularly upward from the pointer position.
module scs8hd_rr_pick
  import scs8hd_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_valid
);

  // Walk the search order ptr, ptr+1, ... (mod N_REQ) and keep the first hit.
  always_comb begin
    int pos;
    o_pick  = '0;
    o_valid = 1'b0;
    pos     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = int'(i_ptr) + i;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (!o_valid && (j == pos) && i_req[j]) begin
          o_pick[j] = 1'b1;
          o_valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scs8hd_rr_arb_ctl.sv
// Round-robin arbiter that shares one scs8hd combinational resource between
// N_REQ requesters. Grants are registered and one-hot, held while the owner
// keeps requesting, optionally revoked after MAX_HOLD cycles, and separated
// by a one-cycle all-zero gap between owners.
module scs8hd_rr_arb_ctl
  import scs8hd_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic [2:0]       GNT_ID,
  output logic             BUSY,
  output logic             TIMEOUT
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam bit               HOLD_EN    = (MAX_HOLD != 0);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(N_REQ - 1);

  arbState_t        r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [PTR_W-1:0] r_gntId;
  logic             r_busy;
  logic             r_timeout;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_hcnt;

  logic [N_REQ-1:0]     w_pick;
  logic                 w_valid;
  logic [MAX_N_REQ-1:0] w_pickWide;
  logic [PTR_W-1:0]     w_pickId;
  logic                 w_ownerReq;
  logic                 w_holdExpired;
  logic [PTR_W-1:0]     w_nextPtr;

  scs8hd_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_valid (w_valid)
  );

  // Widen the pick to the package's maximum size so the shared index helper applies.
  always_comb begin
    w_pickWide              = '0;
    w_pickWide[N_REQ-1:0]   = w_pick;
    w_pickId                = onehotToIndex(w_pickWide);
  end

  // Owner status, hold expiry and the pointer just past the current owner.
  always_comb begin
    w_ownerReq    = |(REQ & r_gnt);
    w_holdExpired = HOLD_EN && (r_hcnt == HOLD_LIMIT);
    w_nextPtr     = (r_gntId == LAST_IDX) ? '0 : (r_gntId + PTR_W'(1));
  end

  // Arbitration FSM with all outputs registered; a release or revoke always
  // passes through TURN so owners are separated by an all-zero grant cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gntId   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_hcnt    <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE, TURN: begin
          if (w_valid) begin
            r_state <= OWN;
            r_gnt   <= w_pick;
            r_gntId <= w_pickId;
            r_busy  <= 1'b1;
            r_hcnt  <= CNT_W'(1);
          end else begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_gntId <= '0;
            r_busy  <= 1'b0;
          end
        end
        OWN: begin
          if (!w_ownerReq || w_holdExpired) begin
            r_state   <= TURN;
            r_gnt     <= '0;
            r_gntId   <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= w_nextPtr;
            r_timeout <= w_ownerReq;
          end else if (r_hcnt != '1) begin
            r_hcnt <= r_hcnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_gntId <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT     = r_gnt;
  assign GNT_ID  = r_gntId;
  assign BUSY    = r_busy;
  assign TIMEOUT = r_timeout;

endmodule

// File: tb/tb_scs8hd_rr_arb_ctl.sv
// Testbench for scs8hd_rr_arb_ctl: four instances with different hold limits
// and requester counts, each compared every cycle against an ownership model.
module tb_scs8hd_rr_arb_ctl;

  logic       CLK;
  logic       reset;
  logic [7:0] reqV [4];

  logic [3:0] gnt0, gnt1, gnt2;
  logic [4:0] gnt3;
  logic [2:0] gntId0, gntId1, gntId2, gntId3;
  logic       busy0, busy1, busy2, busy3;
  logic       to0, to1, to2, to3;

  int checkCount = 0;
  int failCount  = 0;
  int cycle      = 0;

  // Per-instance configuration mirrored from the instantiations below.
  int nReq    [4] = '{4, 4, 4, 5};
  int maxHold [4] = '{16, 4, 0, 3};
  int satMax  [4] = '{31, 31, 31, 7};

  // Ownership model: current owner (-1 = none), cycles held, rotation start.
  int mOwner [4];
  int mHeld  [4];
  int mPtr   [4];
  bit mTo    [4];

  scs8hd_rr_arb_ctl #(.N_REQ(4), .MAX_HOLD(16), .CNT_W(5)) dut0 (
`ifdef SC_USE_PG_PIN
    .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0),
`endif
    .CLK(CLK), .RESET(reset), .REQ(reqV[0][3:0]),
    .GNT(gnt0), .GNT_ID(gntId0), .BUSY(busy0), .TIMEOUT(to0));

  scs8hd_rr_arb_ctl #(.N_REQ(4), .MAX_HOLD(4), .CNT_W(5)) dut1 (
`ifdef SC_USE_PG_PIN
    .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0),
`endif
    .CLK(CLK), .RESET(reset), .REQ(reqV[1][3:0]),
    .GNT(gnt1), .GNT_ID(gntId1), .BUSY(busy1), .TIMEOUT(to1));

  scs8hd_rr_arb_ctl #(.N_REQ(4), .MAX_HOLD(0), .CNT_W(5)) dut2 (
`ifdef SC_USE_PG_PIN
    .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0),
`endif
    .CLK(CLK), .RESET(reset), .REQ(reqV[2][3:0]),
    .GNT(gnt2), .GNT_ID(gntId2), .BUSY(busy2), .TIMEOUT(to2));

  scs8hd_rr_arb_ctl #(.N_REQ(5), .MAX_HOLD(3), .CNT_W(3)) dut3 (
`ifdef SC_USE_PG_PIN
    .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0),
`endif
    .CLK(CLK), .RESET(reset), .REQ(reqV[3][4:0]),
    .GNT(gnt3), .GNT_ID(gntId3), .BUSY(busy3), .TIMEOUT(to3));

  // Free-running clock, 10 time units per period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, observed, expected);
    end
  endtask

  // Advances the model of one instance by one clock edge.
  task automatic modelStep(input int k, input bit rst, input logic [7:0] req);
    bit found;
    int c;
    if (rst) begin
      mOwner[k] = -1;
      mHeld[k]  = 0;
      mPtr[k]   = 0;
      mTo[k]    = 1'b0;
    end else if (mOwner[k] >= 0) begin
      mTo[k] = 1'b0;
      if (!req[mOwner[k]]) begin
        mPtr[k]   = (mOwner[k] + 1) % nReq[k];
        mOwner[k] = -1;
      end else if (maxHold[k] != 0 && mHeld[k] == maxHold[k]) begin
        mPtr[k]   = (mOwner[k] + 1) % nReq[k];
        mOwner[k] = -1;
        mTo[k]    = 1'b1;
      end else if (mHeld[k] < satMax[k]) begin
        mHeld[k]++;
      end
    end else begin
      mTo[k] = 1'b0;
      found  = 1'b0;
      for (int j = 0; j < nReq[k]; j++) begin
        c = (mPtr[k] + j) % nReq[k];
        if (!found && req[c]) begin
          found     = 1'b1;
          mOwner[k] = c;
          mHeld[k]  = 1;
        end
      end
    end
  endtask

  // Compares one instance's outputs with the model.
  task automatic checkInst(input int k, input logic [7:0] gnt, input logic [2:0] id,
                           input logic busy, input logic to);
    logic [7:0] expGnt;
    logic [2:0] expId;
    expGnt = (mOwner[k] >= 0) ? (8'd1 << mOwner[k]) : 8'd0;
    expId  = (mOwner[k] >= 0) ? 3'(mOwner[k]) : 3'd0;
    checkOutput($sformatf("i%0d.gnt", k), 32'(gnt), 32'(expGnt));
    checkOutput($sformatf("i%0d.gntId", k), 32'(id), 32'(expId));
    checkOutput($sformatf("i%0d.busy", k), 32'(busy), 32'(mOwner[k] >= 0));
    checkOutput($sformatf("i%0d.timeout", k), 32'(to), 32'(mTo[k]));
  endtask

  // One clock: model follows the sampled inputs, outputs checked 1 unit later.
  task automatic stepCycle();
    @(posedge CLK);
    for (int k = 0; k < 4; k++) modelStep(k, reset, reqV[k]);
    #1;
    cycle++;
    checkInst(0, {4'b0, gnt0}, gntId0, busy0, to0);
    checkInst(1, {4'b0, gnt1}, gntId1, busy1, to1);
    checkInst(2, {4'b0, gnt2}, gntId2, busy2, to2);
    checkInst(3, {3'b0, gnt3}, gntId3, busy3, to3);
  endtask

  // Drives the same request pattern and reset level into every instance.
  task automatic applyStimulus(input logic [7:0] req, input bit rst);
    reset = rst;
    for (int k = 0; k < 4; k++) reqV[k] = req;
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  initial begin
    applyStimulus(8'hFF, 1'b1);
    runCycles(2);
    checkOutput("rstBusy", 32'(busy0), 32'd0);

    // First grant after reset goes to requester 0.
    applyStimulus(8'hFF, 1'b0);
    runCycles(1);
    checkOutput("relGnt", 32'(gnt0), 32'h1);

    // Single requester releasing after three cycles.
    applyStimulus(8'h00, 1'b1);
    runCycles(1);
    applyStimulus(8'h04, 1'b0);
    runCycles(3);
    checkOutput("relId", 32'(gntId0), 32'd2);
    applyStimulus(8'h00, 1'b0);
    runCycles(2);
    applyStimulus(8'h0F, 1'b0);
    runCycles(1);
    checkOutput("ptrAfterRel", 32'(gnt0), 32'h8);

    // Everyone requesting: round-robin with revokes.
    applyStimulus(8'hFF, 1'b1);
    runCycles(1);
    applyStimulus(8'hFF, 1'b0);
    runCycles(90);

    // Lone requester revoked and regranted.
    applyStimulus(8'h00, 1'b1);
    runCycles(1);
    applyStimulus(8'h02, 1'b0);
    runCycles(20);

    // Reset in the second cycle of ownership by requester 3.
    applyStimulus(8'h00, 1'b1);
    runCycles(1);
    applyStimulus(8'h08, 1'b0);
    runCycles(2);
    applyStimulus(8'h08, 1'b1);
    runCycles(1);
    checkOutput("midRstGnt", 32'(gnt0), 32'h0);
    applyStimulus(8'h09, 1'b0);
    runCycles(1);
    checkOutput("postRstGnt", 32'(gnt0), 32'h1);

    // Long hold: the untimed instance never drops.
    applyStimulus(8'h00, 1'b1);
    runCycles(1);
    applyStimulus(8'h04, 1'b0);
    runCycles(40);
    checkOutput("noTimeoutGnt", 32'(gnt2), 32'h4);

    // Randomized sticky requests with occasional reset.
    applyStimulus(8'h00, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 4; k++) begin
        for (int b = 0; b < 8; b++) begin
          if ($urandom_range(7) == 0) reqV[k][b] = ~reqV[k][b];
        end
        if ($urandom_range(49) == 0) reqV[k] = 8'h00;
      end
      reset = ($urandom_range(299) == 0);
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
